// File: rtl/box_cache_if.sv
// Request/completion bus shared by BEV->cache and cache->bridge: one-cycle request
// pulse carrying address/direction/write record, one-cycle completion pulse with read record.
interface box_cache_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic [ADDR_W-1:0] addr;
  logic              r_wb;
  logic [DATA_W-1:0] data_w;
  logic              out_valid;
  logic [DATA_W-1:0] data_r;

  modport master (output in_valid, addr, r_wb, data_w, input  out_valid, data_r);
  modport slave  (input  in_valid, addr, r_wb, data_w, output out_valid, data_r);
endinterface

// File: rtl/box_cache.sv
// Direct-mapped write-back record cache between the BEV controller (up) and the AXI bridge (dn),
// with a flush engine that writes every dirty line back.
module box_cache #(
  parameter int LINES  = 16,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  box_cache_if.slave  up,
  box_cache_if.master dn,
  input  logic        flush,
  output logic        flush_done,
  output logic        busy
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(LINES - 1);

  typedef enum logic [3:0] {
    IDLE, LOOKUP, EVICT, EVWAIT, FILL, FLWAIT, RESP, FSCAN, FWAIT, FDONE
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              rd;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
    logic              rwb;
    logic [DATA_W-1:0] data;
  } dnReq_t;

  state_t stateQ, stateNxt;
  req_t   req;
  logic [IDX_W-1:0] ptr, ptrNxt;
  logic   flushPend, flushPendNxt;

  logic [LINES-1:0] lineValid, lineDirty;
  logic [TAG_W-1:0]  lineTag  [LINES];
  logic [DATA_W-1:0] lineData [LINES];

  logic              upOutValidQ, upVldNxt;
  logic [DATA_W-1:0] upDataRQ, upDataNxt;
  dnReq_t            dnQ, dnNxt;
  logic              flushDoneQ, flushDoneNxt;
  logic              busyQ;

  logic              capEn, instEn, instDirty, clrEn;
  logic [DATA_W-1:0] instData;
  logic [IDX_W-1:0]  clrIdx;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] reqTag;
  logic             hit, victimDirty, scanDirty;

  assign idx         = req.addr[IDX_W-1:0];
  assign reqTag      = req.addr[ADDR_W-1:IDX_W];
  assign hit         = lineValid[idx] && (lineTag[idx] == reqTag);
  assign victimDirty = lineValid[idx] && lineDirty[idx];
  assign scanDirty   = lineValid[ptr] && lineDirty[ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) stateQ <= IDLE;
    else        stateQ <= stateNxt;
  end

  always_comb begin
    stateNxt     = stateQ;
    ptrNxt       = ptr;
    flushPendNxt = flushPend;
    capEn        = 1'b0;
    instEn       = 1'b0;
    instDirty    = 1'b0;
    instData     = req.wdata;
    clrEn        = 1'b0;
    clrIdx       = idx;
    upVldNxt     = 1'b0;
    upDataNxt    = '0;
    dnNxt        = '0;
    flushDoneNxt = 1'b0;

    // The flush engine absorbs flush pulses; anywhere else they are remembered.
    if (flush && !(stateQ inside {FSCAN, FWAIT, FDONE}) && (stateQ != IDLE || up.in_valid))
      flushPendNxt = 1'b1;

    case (stateQ)
      IDLE: begin
        if (up.in_valid) begin
          capEn    = 1'b1;
          stateNxt = LOOKUP;
        end else if (flush || flushPend) begin
          ptrNxt   = '0;
          stateNxt = FSCAN;
        end
      end
      LOOKUP: begin
        if (hit) begin
          stateNxt = RESP;
          upVldNxt = 1'b1;
          if (req.rd) upDataNxt = lineData[idx];
          else begin
            instEn    = 1'b1;
            instDirty = 1'b1;
          end
        end else if (victimDirty) begin
          stateNxt   = EVICT;
          dnNxt.vld  = 1'b1;
          dnNxt.addr = {lineTag[idx], idx};
          dnNxt.data = lineData[idx];
        end else if (req.rd) begin
          stateNxt   = FILL;
          dnNxt.vld  = 1'b1;
          dnNxt.rwb  = 1'b1;
          dnNxt.addr = req.addr;
        end else begin
          // whole record is overwritten, so a write miss never fills
          instEn    = 1'b1;
          instDirty = 1'b1;
          stateNxt  = RESP;
          upVldNxt  = 1'b1;
        end
      end
      EVICT: stateNxt = EVWAIT;
      EVWAIT: begin
        if (dn.out_valid) begin
          clrEn = 1'b1;
          if (req.rd) begin
            stateNxt   = FILL;
            dnNxt.vld  = 1'b1;
            dnNxt.rwb  = 1'b1;
            dnNxt.addr = req.addr;
          end else begin
            instEn    = 1'b1;
            instDirty = 1'b1;
            stateNxt  = RESP;
            upVldNxt  = 1'b1;
          end
        end
      end
      FILL: stateNxt = FLWAIT;
      FLWAIT: begin
        if (dn.out_valid) begin
          instEn    = 1'b1;
          instData  = dn.data_r;
          stateNxt  = RESP;
          upVldNxt  = 1'b1;
          upDataNxt = dn.data_r;
        end
      end
      RESP: stateNxt = IDLE;
      FSCAN: begin
        if (scanDirty) begin
          stateNxt   = FWAIT;
          dnNxt.vld  = 1'b1;
          dnNxt.addr = {lineTag[ptr], ptr};
          dnNxt.data = lineData[ptr];
        end else if (ptr == LAST) begin
          stateNxt     = FDONE;
          flushDoneNxt = 1'b1;
        end else begin
          ptrNxt = ptr + IDX_W'(1);
        end
      end
      FWAIT: begin
        if (dn.out_valid) begin
          clrEn  = 1'b1;
          clrIdx = ptr;
          if (ptr == LAST) begin
            stateNxt     = FDONE;
            flushDoneNxt = 1'b1;
          end else begin
            ptrNxt   = ptr + IDX_W'(1);
            stateNxt = FSCAN;
          end
        end
      end
      FDONE: begin
        flushPendNxt = 1'b0;
        stateNxt     = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lineValid   <= '0;
      lineDirty   <= '0;
      flushPend   <= 1'b0;
      ptr         <= '0;
      upOutValidQ <= 1'b0;
      upDataRQ    <= '0;
      dnQ         <= '0;
      flushDoneQ  <= 1'b0;
      busyQ       <= 1'b0;
    end else begin
      flushPend   <= flushPendNxt;
      ptr         <= ptrNxt;
      upOutValidQ <= upVldNxt;
      upDataRQ    <= upDataNxt;
      dnQ         <= dnNxt;
      flushDoneQ  <= flushDoneNxt;
      busyQ       <= (stateNxt != IDLE);
      if (clrEn) lineDirty[clrIdx] <= 1'b0;
      // an install on the same line overrides the eviction's dirty clear
      if (instEn) begin
        lineValid[idx] <= 1'b1;
        lineDirty[idx] <= instDirty;
      end
    end
  end

  // Payload storage carries no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (capEn) req <= '{addr: up.addr, rd: up.r_wb, wdata: up.data_w};
    if (instEn && rst_n) begin
      lineTag[idx]  <= reqTag;
      lineData[idx] <= instData;
    end
  end

  assign up.out_valid = upOutValidQ;
  assign up.data_r    = upDataRQ;
  assign dn.in_valid  = dnQ.vld;
  assign dn.addr      = dnQ.addr;
  assign dn.r_wb      = dnQ.rwb;
  assign dn.data_w    = dnQ.data;
  assign flush_done   = flushDoneQ;
  assign busy         = busyQ;
endmodule

// File: tb/tb_box_cache.sv
// Bench for box_cache: a pseudo-DRAM bridge with random latency, directed scenarios,
// and a random read/write mix checked against a flat memory-image reference model.
module tb_box_cache;
  localparam int LINES = 16, ADDR_W = 8, DATA_W = 64;

  typedef struct {
    logic [7:0]  a;
    logic        rwb;
    logic [63:0] d;
  } txn_t;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic flushDone, busy;
  int   errors = 0, checks = 0;
  logic [63:0] dram [256];
  txn_t dnLog[$];
  bit   brHold = 1'b0;

  box_cache_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) upBus();
  box_cache_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dnBus();

  box_cache #(.LINES(LINES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .up(upBus), .dn(dnBus),
    .flush(flush), .flush_done(flushDone), .busy(busy)
  );

  always #5 clk = ~clk;

  // Bridge + DRAM: responds 1..4 cycles after each request, abandons on reset.
  initial begin : bridge
    bit   pend, prevIn;
    int   dly;
    txn_t cur;
    pend = 0; prevIn = 0; dly = 0;
    cur = '{8'h0, 1'b0, 64'h0};
    dnBus.out_valid = 1'b0; dnBus.data_r = '0;
    forever begin
      @(negedge clk);
      dnBus.out_valid = 1'b0; dnBus.data_r = '0;
      if (!rst_n) begin
        pend = 0; prevIn = 0;
      end else begin
        if (pend && !brHold) begin
          if (dly == 0) begin
            if (cur.rwb) dnBus.data_r = dram[cur.a];
            else         dram[cur.a] = cur.d;
            dnBus.out_valid = 1'b1;
            pend = 0;
          end else dly--;
        end
        if (dnBus.in_valid === 1'b1) begin
          checks++;
          if (prevIn || pend) begin
            errors++;
            $display("FAIL dn_handshake prev_in_valid=%0b outstanding=%0b required 0/0", prevIn, pend);
          end
          cur = '{dnBus.addr, dnBus.r_wb, dnBus.data_w};
          dnLog.push_back(cur);
          pend = 1;
          dly  = $urandom_range(0, 3);
        end
        prevIn = (dnBus.in_valid === 1'b1);
      end
    end
  end

  task automatic doReset();
    rst_n = 1'b0; flush = 1'b0;
    upBus.in_valid = 1'b0; upBus.addr = '0; upBus.r_wb = 1'b0; upBus.data_w = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dnLog.delete();
  endtask

  // One request; lat counts negedges after the request cycle (2 means T+2).
  task automatic doReq(input logic [7:0] a, input logic rd, input logic [63:0] wd,
                       output logic [63:0] rdat, output int lat, output int ndn);
    dnLog.delete();
    @(negedge clk);
    upBus.in_valid = 1'b1; upBus.addr = a; upBus.r_wb = rd; upBus.data_w = wd;
    @(negedge clk);
    upBus.in_valid = 1'b0;
    lat = 1;
    while (upBus.out_valid !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    if (upBus.out_valid !== 1'b1) begin
      checks++; errors++;
      $display("FAIL req_timeout addr=%h no up_out_valid within 300 cycles", a);
      lat = -1;
    end
    rdat = upBus.data_r;
    ndn  = dnLog.size();
  endtask

  task automatic doFlush(output int pulses, output int ndn);
    int cyc;
    dnLog.delete();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    pulses = 0; cyc = 0;
    while (cyc < 600 && !(pulses > 0 && busy === 1'b0)) begin
      if (flushDone === 1'b1) pulses++;
      @(negedge clk);
      cyc++;
    end
    repeat (5) begin
      if (flushDone === 1'b1) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses == 0) begin errors++; $display("FAIL flush_timeout flush_done never seen, required 1 pulse"); end
    ndn = dnLog.size();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    upBus.in_valid = 1'b0; upBus.addr = '0; upBus.r_wb = 1'b0; upBus.data_w = '0;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({upBus.out_valid, upBus.data_r, dnBus.in_valid, dnBus.addr, dnBus.r_wb, dnBus.data_w, flushDone, busy} !== '0) begin
      errors++; $display("FAIL reset_outputs some output nonzero during reset, required all 0");
    end
    rst_n = 1'b1;
    dnLog.delete();
    @(negedge clk);
    checks++;
    if ({upBus.out_valid, upBus.data_r} !== '0) begin
      errors++; $display("FAIL idle_up out_valid=%b data_r=%h required 0/0", upBus.out_valid, upBus.data_r);
    end
    checks++;
    if ({dnBus.in_valid, dnBus.addr, dnBus.r_wb, dnBus.data_w, flushDone, busy} !== '0) begin
      errors++; $display("FAIL idle_dn in_valid=%b busy=%b flush_done=%b required all 0", dnBus.in_valid, busy, flushDone);
    end
  endtask

  task automatic test_read_miss_hit();
    logic [63:0] rd; int lat, ndn;
    dram[8'h05] = 64'h1111_2222_3333_4444;
    doReq(8'h05, 1'b1, '0, rd, lat, ndn);
    checks++;
    if (rd !== 64'h1111_2222_3333_4444) begin errors++; $display("FAIL miss_data got=%h want=%h", rd, 64'h1111_2222_3333_4444); end
    checks++;
    if (ndn != 1) begin errors++; $display("FAIL miss_dn_count got=%0d want=1", ndn); end
    else if (dnLog[0].a !== 8'h05 || dnLog[0].rwb !== 1'b1) begin
      errors++; $display("FAIL miss_dn_txn got addr=%h rwb=%b want 05/1", dnLog[0].a, dnLog[0].rwb);
    end
    doReq(8'h05, 1'b1, '0, rd, lat, ndn);
    checks++;
    if (rd !== 64'h1111_2222_3333_4444) begin errors++; $display("FAIL hit_data got=%h want=%h", rd, 64'h1111_2222_3333_4444); end
    checks++;
    if (lat != 2 || ndn != 0) begin errors++; $display("FAIL hit_latency got lat=%0d dn=%0d want 2/0", lat, ndn); end
  endtask

  task automatic test_evict();
    logic [63:0] rd, v15; int lat, ndn;
    v15 = 64'hBEEF_0015_CAFE_0015;
    dram[8'h15] = v15;
    doReq(8'h05, 1'b0, 64'hAAAA_0000_0000_0001, rd, lat, ndn);
    checks++;
    if (lat != 2 || ndn != 0 || rd !== 64'h0) begin
      errors++; $display("FAIL write_hit got lat=%0d dn=%0d data_r=%h want 2/0/0", lat, ndn, rd);
    end
    doReq(8'h15, 1'b1, '0, rd, lat, ndn);
    checks++;
    if (ndn != 2) begin errors++; $display("FAIL evict_dn_count got=%0d want=2", ndn); end
    else if (dnLog[0].a !== 8'h05 || dnLog[0].rwb !== 1'b0 || dnLog[0].d !== 64'hAAAA_0000_0000_0001 ||
             dnLog[1].a !== 8'h15 || dnLog[1].rwb !== 1'b1) begin
      errors++; $display("FAIL evict_dn_order got %h/%b/%h then %h/%b want 05/0/aaaa000000000001 then 15/1",
                         dnLog[0].a, dnLog[0].rwb, dnLog[0].d, dnLog[1].a, dnLog[1].rwb);
    end
    checks++;
    if (rd !== v15) begin errors++; $display("FAIL evict_fill_data got=%h want=%h", rd, v15); end
    checks++;
    if (dram[8'h05] !== 64'hAAAA_0000_0000_0001) begin errors++; $display("FAIL evict_dram got=%h want=aaaa000000000001", dram[8'h05]); end
  endtask

  task automatic test_write_miss_flush();
    logic [63:0] rd, v; int lat, ndn, pulses;
    v = 64'h0707_1234_5678_0707;
    doReset();
    doReq(8'h07, 1'b0, v, rd, lat, ndn);
    checks++;
    if (lat != 2 || ndn != 0) begin errors++; $display("FAIL clean_write_miss got lat=%0d dn=%0d want 2/0", lat, ndn); end
    doFlush(pulses, ndn);
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL flush_done_pulses got=%0d want=1", pulses); end
    checks++;
    if (ndn != 1) begin errors++; $display("FAIL flush_dn_count got=%0d want=1", ndn); end
    else if (dnLog[0].a !== 8'h07 || dnLog[0].rwb !== 1'b0 || dnLog[0].d !== v) begin
      errors++; $display("FAIL flush_dn_txn got %h/%b/%h want 07/0/%h", dnLog[0].a, dnLog[0].rwb, dnLog[0].d, v);
    end
    checks++;
    if (dram[8'h07] !== v) begin errors++; $display("FAIL flush_dram got=%h want=%h", dram[8'h07], v); end
  endtask

  task automatic test_flush_collision();
    logic [63:0] rd, v, rdv; int lat, ndn, respCyc, doneCyc, pulses, cnt;
    v = 64'h0303_0303_DEAD_0303;
    doReset();
    doReq(8'h03, 1'b0, v, rd, lat, ndn);
    dnLog.delete();
    @(negedge clk);
    upBus.in_valid = 1'b1; upBus.addr = 8'h03; upBus.r_wb = 1'b1; flush = 1'b1;
    @(negedge clk);
    upBus.in_valid = 1'b0; flush = 1'b0;
    respCyc = -1; doneCyc = -1; pulses = 0; rdv = '0;
    for (int c = 1; c <= 300; c++) begin
      if (upBus.out_valid === 1'b1 && respCyc < 0) begin respCyc = c; rdv = upBus.data_r; end
      if (flushDone === 1'b1) begin pulses++; if (doneCyc < 0) doneCyc = c; end
      @(negedge clk);
    end
    checks++;
    if (respCyc != 2 || rdv !== v) begin errors++; $display("FAIL collide_resp got cyc=%0d data=%h want 2/%h", respCyc, rdv, v); end
    checks++;
    if (pulses != 1 || doneCyc <= respCyc) begin
      errors++; $display("FAIL collide_flush got pulses=%0d done_cyc=%0d resp_cyc=%0d want 1 pulse after resp", pulses, doneCyc, respCyc);
    end
    checks++;
    if (dnLog.size() != 1) begin errors++; $display("FAIL collide_dn_count got=%0d want=1", dnLog.size()); end
    else if (dnLog[0].a !== 8'h03 || dnLog[0].rwb !== 1'b0 || dnLog[0].d !== v) begin
      errors++; $display("FAIL collide_dn_txn got %h/%b/%h want 03/0/%h", dnLog[0].a, dnLog[0].rwb, dnLog[0].d, v);
    end
    // request while busy must be dropped
    dnLog.delete();
    @(negedge clk);
    upBus.in_valid = 1'b1; upBus.addr = 8'h40; upBus.r_wb = 1'b1;
    @(negedge clk);
    upBus.in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_flag got=%b want=1", busy); end
    upBus.in_valid = 1'b1; upBus.addr = 8'h41;
    @(negedge clk);
    upBus.in_valid = 1'b0;
    cnt = 0;
    for (int c = 0; c < 60; c++) begin
      if (upBus.out_valid === 1'b1) cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt != 1 || dnLog.size() != 1) begin
      errors++; $display("FAIL busy_drop got responses=%0d dn=%0d want 1/1", cnt, dnLog.size());
    end
  endtask

  task automatic test_reset_evwait();
    logic [63:0] rd, v, oldV; int lat, ndn, cyc;
    v = 64'h9999_0000_1111_0009; oldV = 64'h5555_6666_7777_8888;
    doReset();
    dram[8'h09] = oldV;
    doReq(8'h09, 1'b0, v, rd, lat, ndn);
    dnLog.delete(); brHold = 1'b1;
    @(negedge clk);
    upBus.in_valid = 1'b1; upBus.addr = 8'h19; upBus.r_wb = 1'b1;
    @(negedge clk);
    upBus.in_valid = 1'b0;
    cyc = 0;
    while (dnLog.size() == 0 && cyc < 50) begin @(negedge clk); cyc++; end
    checks++;
    if (dnLog.size() != 1) begin errors++; $display("FAIL evwait_evict got dn=%0d want=1", dnLog.size()); end
    else if (dnLog[0].a !== 8'h09 || dnLog[0].rwb !== 1'b0 || dnLog[0].d !== v) begin
      errors++; $display("FAIL evwait_evict_txn got %h/%b/%h want 09/0/%h", dnLog[0].a, dnLog[0].rwb, dnLog[0].d, v);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL evwait_busy got=%b want=1", busy); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({upBus.out_valid, upBus.data_r, dnBus.in_valid, dnBus.addr, dnBus.r_wb, dnBus.data_w, flushDone, busy} !== '0) begin
      errors++; $display("FAIL evwait_reset outputs nonzero busy=%b dn_in_valid=%b required all 0", busy, dnBus.in_valid);
    end
    @(negedge clk);
    rst_n = 1'b1; brHold = 1'b0;
    doReq(8'h09, 1'b1, '0, rd, lat, ndn);
    checks++;
    if (ndn != 1) begin errors++; $display("FAIL post_reset_dn got=%0d want=1", ndn); end
    else if (dnLog[0].a !== 8'h09 || dnLog[0].rwb !== 1'b1) begin
      errors++; $display("FAIL post_reset_txn got %h/%b want 09/1", dnLog[0].a, dnLog[0].rwb);
    end
    checks++;
    if (rd !== oldV) begin errors++; $display("FAIL post_reset_data got=%h want=%h", rd, oldV); end
  endtask

  task automatic test_random();
    logic [63:0] truth [256];
    bit          mV [LINES];
    bit          mD [LINES];
    logic [7:0]  mA [LINES];
    logic [63:0] rd, wd;
    logic [7:0]  a;
    logic [3:0]  ix;
    bit          rdOp, resident;
    int          lat, ndn, expDn, dirtyCnt, pulses;
    doReset();
    for (int i = 0; i < 256; i++) begin dram[i] = {$urandom, $urandom}; truth[i] = dram[i]; end
    for (int i = 0; i < LINES; i++) begin mV[i] = 0; mD[i] = 0; mA[i] = '0; end
    for (int n = 0; n < 2000; n++) begin
      a    = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 47)) : 8'($urandom_range(0, 255));
      rdOp = 1'($urandom_range(0, 1));
      wd   = {$urandom, $urandom};
      ix   = a[3:0];
      resident = mV[ix] && (mA[ix] == a);
      expDn = resident ? 0 : ((mV[ix] && mD[ix]) ? 1 : 0) + (rdOp ? 1 : 0);
      doReq(a, rdOp, wd, rd, lat, ndn);
      checks++;
      if (rdOp) begin
        if (rd !== truth[a]) begin errors++; $display("FAIL rand_read op=%0d addr=%h got=%h want=%h", n, a, rd, truth[a]); end
      end else begin
        truth[a] = wd;
        if (rd !== 64'h0) begin errors++; $display("FAIL rand_write_data op=%0d addr=%h got=%h want=0", n, a, rd); end
      end
      checks++;
      if (ndn != expDn) begin errors++; $display("FAIL rand_dn_count op=%0d addr=%h got=%0d want=%0d", n, a, ndn, expDn); end
      if (expDn == 0) begin
        checks++;
        if (lat != 2) begin errors++; $display("FAIL rand_latency op=%0d addr=%h got=%0d want=2", n, a, lat); end
      end
      if (!resident) begin mV[ix] = 1; mA[ix] = a; mD[ix] = 0; end
      if (!rdOp) mD[ix] = 1;
    end
    dirtyCnt = 0;
    for (int i = 0; i < LINES; i++) if (mV[i] && mD[i]) dirtyCnt++;
    doFlush(pulses, ndn);
    checks++;
    if (ndn != dirtyCnt || pulses != 1) begin
      errors++; $display("FAIL rand_flush got writebacks=%0d pulses=%0d want %0d/1", ndn, pulses, dirtyCnt);
    end
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (dram[i] !== truth[i]) begin errors++; $display("FAIL dram_image addr=%h got=%h want=%h", i[7:0], dram[i], truth[i]); end
    end
  endtask

  initial begin
    upBus.in_valid = 1'b0; upBus.addr = '0; upBus.r_wb = 1'b0; upBus.data_w = '0;
    for (int i = 0; i < 256; i++) dram[i] = {$urandom, $urandom};
    test_reset();
    test_read_miss_hit();
    test_evict();
    test_write_miss_flush();
    test_flush_collision();
    test_reset_evwait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish within 90000 cycles");
    $fatal(1, "watchdog");
  end
endmodule
